// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding and width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_wr_arbiter_pkg;

  // Arbiter FSM: IDLE picks an owner, BURST moves words from that owner.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // Bits needed to index 'value' entries; never less than 1 so that
  // degenerate sizes still produce a legal vector.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-facing bundle of the write arbiter.
// Latency: n/a (wires only).
// Backpressure: req_ready per producer, fifo_full from the FIFO.
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = clog2(NUM_REQ)
);

  logic                          enable;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_cs;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic [IDX_W-1:0]              grant_id;
  logic                          busy;

  // Arbiter side.
  modport slave (
    input  enable, req_valid, req_data, fifo_full,
    output req_ready, fifo_cs, fifo_wr_en, fifo_data_in, grant_id, busy
  );

  // Producers, FIFO and control side.
  modport master (
    output enable, req_valid, req_data, fifo_full,
    input  req_ready, fifo_cs, fifo_wr_en, fifo_data_in, grant_id, busy
  );

endinterface

// File: rtl/fifo.sv
// Generic synchronous FIFO with chip select, full/empty flags.
// Latency: write visible to read one cycle later; read data registered (1 cycle).
// Backpressure: writes ignored while full, reads ignored while empty.
module fifo
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_cs,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_wr;
  logic                  w_rd;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_cs & i_wr_en & ~o_full;
  assign w_rd    = i_cs & i_rd_en & ~o_empty;

  // Storage array; no reset needed, occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data_in;
  end

  // Pointers, occupancy and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      o_data_out <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_rd) begin
        r_rd_ptr   <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
        o_data_out <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping upward.
// Latency: combinational.
// Backpressure: none.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  // Walk from the farthest offset down to ptr so the nearest hit wins.
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, bursts of up to MAX_BURST.
// Latency: one IDLE arbitration cycle, then a word per cycle written on the same edge it is accepted.
// Backpressure: fifo_full holds the grant without transfer; ready never depends on valid.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_t            r_state;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [IDX_W-1:0]      r_owner;
  logic [CNT_W-1:0]      r_burst_cnt;
  logic [IDX_W-1:0]      r_grant_id;
  logic                  r_busy;

  logic                  w_pick_any;
  logic [IDX_W-1:0]      w_pick_idx;
  logic                  w_owner_vld;
  logic                  w_grant_rdy;
  logic                  w_xfer;
  logic                  w_release;
  logic [IDX_W-1:0]      w_next_ptr;
  logic [DATA_WIDTH-1:0] w_owner_data;

  fifo_wr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req (bus.req_valid),
    .ptr (r_rr_ptr),
    .any (w_pick_any),
    .idx (w_pick_idx)
  );

  // The owner may accept whenever enabled and the FIFO has room.
  assign w_owner_vld  = bus.req_valid[r_owner];
  assign w_owner_data = bus.req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
  assign w_grant_rdy  = (r_state == ST_BURST) & bus.enable & ~bus.fifo_full;
  assign w_xfer       = w_grant_rdy & w_owner_vld;

  // Full alone never releases: an empty owner or disable does, as does the final beat.
  assign w_release  = (w_xfer && (r_burst_cnt == LAST_BEAT)) || !w_owner_vld || !bus.enable;
  assign w_next_ptr = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

  assign bus.req_ready    = w_grant_rdy ? (NUM_REQ'(1) << r_owner) : '0;
  assign bus.fifo_wr_en   = w_xfer;
  assign bus.fifo_data_in = w_xfer ? w_owner_data : '0;
  assign bus.fifo_cs      = bus.enable;
  assign bus.grant_id     = r_grant_id;
  assign bus.busy         = r_busy;

  // Grant/burst FSM with registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_grant_id  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.enable && w_pick_any) begin
            r_state     <= ST_BURST;
            r_owner     <= w_pick_idx;
            r_grant_id  <= w_pick_idx;
            r_burst_cnt <= '0;
            r_busy      <= 1'b1;
          end
        end
        ST_BURST: begin
          if (w_release) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= w_next_ptr;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
          end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter driving a real 8-deep fifo.
// Latency: n/a.
// Backpressure: the fifo full flag is fed back to the arbiter.
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rd_en;
  logic          empty;
  logic          full_w;
  logic [DW-1:0] dout;

  logic [NR-1:0] p_en;
  logic [NR-1:0] fire_prev;
  int            p_idx [NR];
  int            p_lim [NR];
  logic          tb_en;
  logic          tb_rd;
  int            n_err;
  int            n_checks;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();
  assign bus.fifo_full = full_w;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  fifo #(.DATA_WIDTH(DW), .DEPTH(8)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_cs       (bus.fifo_cs),
    .i_wr_en    (bus.fifo_wr_en),
    .i_rd_en    (rd_en),
    .i_data_in  (bus.fifo_data_in),
    .o_data_out (dout),
    .o_full     (full_w),
    .o_empty    (empty)
  );

  function automatic logic [31:0] word(input int i, input int k);
    return 32'hD000_0000 | 32'(i << 12) | 32'(k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic b, input int g,
                            input logic [NR-1:0] rdy, input logic w, input logic [31:0] d);
    chk({tag, ".busy"},  32'(bus.busy),         32'(b));
    chk({tag, ".grant"}, 32'(bus.grant_id),     32'(g));
    chk({tag, ".ready"}, 32'(bus.req_ready),    32'(rdy));
    chk({tag, ".wr_en"}, 32'(bus.fifo_wr_en),   32'(w));
    chk({tag, ".data"},  bus.fifo_data_in,      d);
    chk({tag, ".cs"},    32'(bus.fifo_cs),      32'(tb_en));
  endtask

  // One cycle: advance producers that were accepted, present words, then settle.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (fire_prev[i]) p_idx[i]++;
      bus.req_data[i*DW +: DW] = word(i, p_idx[i]);
      bus.req_valid[i] = p_en[i] && (p_idx[i] < p_lim[i]);
    end
    bus.enable = tb_en;
    rd_en = tb_rd;
    #1;
    fire_prev = bus.req_valid & bus.req_ready;
  endtask

  task automatic clear_producers();
    p_en = '0;
    fire_prev = '0;
    for (int i = 0; i < NR; i++) begin
      p_idx[i] = 0;
      p_lim[i] = 1000;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_producers();
    tb_rd = 1'b0;
    rd_en = 1'b0;
    tb_en = 1'b1;
    bus.enable = 1'b1;
    bus.req_valid = '0;
    #1;
    expect_out("rst", 0, 0, 4'b0000, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    n_err = 0;
    n_checks = 0;
    reset_n = 1'b1;
    tb_en = 1'b1;
    tb_rd = 1'b0;
    rd_en = 1'b0;
    clear_producers();
    bus.enable = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    #1 reset_n = 1'b0;
    #1;
    expect_out("por", 0, 0, 4'b0000, 0, 0);
    chk("por.empty", 32'(empty), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Single producer 1, six words: burst of 4, gap, then 2, then release.
    p_en[1] = 1'b1;
    p_lim[1] = 6;
    step(); expect_out("t1.idle", 0, 0, 4'b0000, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(); expect_out($sformatf("t1.b%0d", k), 1, 1, 4'b0010, 1, word(1, k));
    end
    step(); expect_out("t1.gap", 0, 0, 4'b0000, 0, 0);
    for (int k = 4; k < 6; k++) begin
      step(); expect_out($sformatf("t1.b%0d", k), 1, 1, 4'b0010, 1, word(1, k));
    end
    step(); expect_out("t1.drop", 1, 1, 4'b0010, 0, 0);
    step(); expect_out("t1.rel", 0, 0, 4'b0000, 0, 0);
    tb_rd = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      tb_rd = (k < 5);
      step();
      chk($sformatf("t1.rd%0d", k), dout, word(1, k));
    end
    chk("t1.empty", 32'(empty), 32'd1);

    // All four producers valid: grants 0,1,2,3,0 with four words each and a gap per handoff.
    do_reset();
    tb_rd = 1'b1;
    p_en = '1;
    for (int g = 0; g < 5; g++) begin
      step(); expect_out($sformatf("t2.gap%0d", g), 0, 0, 4'b0000, 0, 0);
      for (int b = 0; b < 4; b++) begin
        step();
        expect_out($sformatf("t2.g%0d.b%0d", g, b), 1, g % 4, 4'(1 << (g % 4)), 1,
                   word(g % 4, (g / 4) * 4 + b));
      end
    end

    // Producer 2 fills the FIFO, stalls on full, resumes after one read, nothing lost.
    do_reset();
    p_en[2] = 1'b1;
    for (int g = 0; g < 2; g++) begin
      step(); expect_out($sformatf("t3.gap%0d", g), 0, 0, 4'b0000, 0, 0);
      for (int b = 0; b < 4; b++) begin
        step(); expect_out($sformatf("t3.b%0d", g * 4 + b), 1, 2, 4'b0100, 1, word(2, g * 4 + b));
      end
    end
    step(); expect_out("t3.gap2", 0, 0, 4'b0000, 0, 0);
    chk("t3.full", 32'(full_w), 32'd1);
    step(); expect_out("t3.stall0", 1, 2, 4'b0000, 0, 0);
    tb_rd = 1'b1;
    step(); expect_out("t3.stall1", 1, 2, 4'b0000, 0, 0);
    tb_rd = 1'b0;
    step(); expect_out("t3.resume", 1, 2, 4'b0100, 1, word(2, 8));
    chk("t3.rd0", dout, word(2, 0));
    step(); expect_out("t3.stall2", 1, 2, 4'b0000, 0, 0);
    p_en[2] = 1'b0;
    tb_rd = 1'b1;
    step(); expect_out("t3.drop", 1, 2, 4'b0000, 0, 0);
    for (int k = 1; k < 9; k++) begin
      tb_rd = (k < 8);
      step();
      chk($sformatf("t3.rd%0d", k), dout, word(2, k));
    end
    chk("t3.empty", 32'(empty), 32'd1);

    // Owner 0 drops after two words; producer 3 takes over with a fresh burst count.
    do_reset();
    tb_rd = 1'b1;
    p_en[0] = 1'b1;
    p_lim[0] = 2;
    p_en[3] = 1'b1;
    step(); expect_out("t4.idle", 0, 0, 4'b0000, 0, 0);
    step(); expect_out("t4.a0", 1, 0, 4'b0001, 1, word(0, 0));
    step(); expect_out("t4.a1", 1, 0, 4'b0001, 1, word(0, 1));
    step(); expect_out("t4.drop", 1, 0, 4'b0001, 0, 0);
    step(); expect_out("t4.gap", 0, 0, 4'b0000, 0, 0);
    for (int b = 0; b < 4; b++) begin
      step(); expect_out($sformatf("t4.d%0d", b), 1, 3, 4'b1000, 1, word(3, b));
    end
    step(); expect_out("t4.gap2", 0, 0, 4'b0000, 0, 0);
    step(); expect_out("t4.d4", 1, 3, 4'b1000, 1, word(3, 4));

    // Reset in the middle of producer 2's burst; afterwards the scan restarts at 0.
    do_reset();
    tb_rd = 1'b1;
    p_en[2] = 1'b1;
    step(); expect_out("t5.idle", 0, 0, 4'b0000, 0, 0);
    step(); expect_out("t5.c0", 1, 2, 4'b0100, 1, word(2, 0));
    step(); expect_out("t5.c1", 1, 2, 4'b0100, 1, word(2, 1));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t5.vld_held", 32'(bus.req_valid), 32'(4'b0100));
    expect_out("t5.mid_rst", 0, 0, 4'b0000, 0, 0);
    clear_producers();
    bus.req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    p_en = 4'b0110;
    step(); expect_out("t5.idle2", 0, 0, 4'b0000, 0, 0);
    step(); expect_out("t5.b0", 1, 1, 4'b0010, 1, word(1, 0));

    // Enable low blocks grants; dropping it mid-burst releases and advances the pointer.
    do_reset();
    tb_en = 1'b0;
    p_en[0] = 1'b1;
    step(); expect_out("t6.off0", 0, 0, 4'b0000, 0, 0);
    step(); expect_out("t6.off1", 0, 0, 4'b0000, 0, 0);
    tb_en = 1'b1;
    step(); expect_out("t6.idle", 0, 0, 4'b0000, 0, 0);
    step(); expect_out("t6.a0", 1, 0, 4'b0001, 1, word(0, 0));
    step(); expect_out("t6.a1", 1, 0, 4'b0001, 1, word(0, 1));
    tb_en = 1'b0;
    p_en[1] = 1'b1;
    step(); expect_out("t6.drop_en", 1, 0, 4'b0000, 0, 0);
    tb_en = 1'b1;
    step(); expect_out("t6.gap", 0, 0, 4'b0000, 0, 0);
    step(); expect_out("t6.b0", 1, 1, 4'b0010, 1, word(1, 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
